vote_capture: RTL and testbench
===============================

Name: vote_capture

Overview:
- Front-end stage of the voting machine. Sits directly upstream of the per-candidate vote logger and produces that block's four cand*_vote_valid inputs.
- Synchronises and debounces four raw candidate push-buttons.
- Enforces one vote per press: exactly one single-cycle valid pulse per accepted press, followed by a lockout and wait-for-release.
- Rejects ambiguous multi-button presses and ignores buttons while the machine is in result mode.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised samples required before a debounced level changes; legal range 2..255.
- LOCKOUT_CYCLES, 64: clocks after an accepted vote during which all presses are ignored; legal range 1..65535.

Ports:
- clock  input  1  system clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset (assert = 0)
- mode  input  1  0 = voting, 1 = result; synchronous, already in clock domain
- button1  input  1  raw asynchronous candidate-1 button, active-high
- button2  input  1  raw asynchronous candidate-2 button, active-high
- button3  input  1  raw asynchronous candidate-3 button, active-high
- button4  input  1  raw asynchronous candidate-4 button, active-high
- cand1_vote_valid  output  1  one-cycle pulse: accepted vote for candidate 1
- cand2_vote_valid  output  1  one-cycle pulse: accepted vote for candidate 2
- cand3_vote_valid  output  1  one-cycle pulse: accepted vote for candidate 3
- cand4_vote_valid  output  1  one-cycle pulse: accepted vote for candidate 4
- vote_reject  output  1  one-cycle pulse: ambiguous press discarded
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, async): synchroniser flops, debounce counters, debounced levels, lockout counter and all outputs go to 0. FSM goes to IDLE. Takes effect immediately, mid-operation included; no pulse is emitted after release of reset until a new press completes debounce.
- Synchroniser: 2 flops per button. sync_i is the second-flop output.
- Debounce, per button:
  - 8-bit counter clears whenever sync_i equals the debounced level deb_i.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 and sync_i still differs, deb_i toggles and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES clocks never change deb_i.
- Press event: press_i = deb_i rising (registered deb_i compare).
- FSM states: IDLE, VOTE, REJECT, LOCK, WAIT_REL.
- IDLE:
  - mode=1: all press events ignored; stay IDLE.
  - mode=0 and exactly one press_i with all other deb_j low: latch index i, go to VOTE.
  - mode=0 and any press_i with two or more deb high (simultaneous presses, or a press while another button is held): go to REJECT.
- VOTE: one cycle; drive cand{i}_vote_valid=1; load lockout counter with LOCKOUT_CYCLES-1; go to LOCK.
- REJECT: one cycle; vote_reject=1; go to WAIT_REL.
- LOCK: count down to 0, then go to WAIT_REL. Presses are ignored.
- WAIT_REL: stay until all deb_i=0, then go to IDLE. A button held through lockout never produces a second vote.
- mode changes outside IDLE do not abort the sequence.
- Outputs are registered; at most one of the five pulse outputs is high in any cycle. Valid is never high two consecutive cycles.
- Latency: a clean raw press held steady produces cand*_vote_valid DEBOUNCE_CYCLES+3 clocks after the first rising edge that samples it (+1 clock for sampling phase).
- Minimum spacing between two accepted votes: 1 + LOCKOUT_CYCLES + release debounce.

Optional Feature:
- Macro: VOTE_CAPTURE_TOTAL_EN.
- Defined:
  - Adds output total_votes [7:0], reset 0.
  - Increments in the cycle after any cand*_vote_valid pulse; saturates at 255 (no wrap).
  - Adds output reject_count [3:0], incremented on vote_reject, saturates at 15.
- Undefined: neither port nor the counters exist. Core behaviour is identical.

Test Plan:
- DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8; button2 high for 20 clocks -> exactly one cand2_vote_valid pulse, 7±1 clocks after press; no other outputs; busy high until release is debounced.
- button1 glitch high for 3 clocks, repeated 5 times -> no valid, no reject, busy stays 0.
- button3 and button4 rise in the same clock, held 10 clocks -> one vote_reject pulse, no cand valid; after release, a button3 press gives one cand3_vote_valid.
- mode=1, press button1 -> no output. mode=0, press button1 -> one cand1_vote_valid. Hold button1 across lockout -> no second pulse until released and re-pressed.
- Assert reset=0 during LOCK, then release -> all outputs 0 immediately, FSM in IDLE. The next clean button4 press yields one cand4_vote_valid.
- VOTE_CAPTURE_TOTAL_EN defined, 260 accepted votes -> total_votes reaches 255 and holds. 3 rejects -> reject_count = 3.

Source files
------------

// File: rtl/vote_capture.sv
// rtl/vote_capture.sv - button synchroniser, debouncer and one-vote-per-press capture FSM
//
// Ports:
//   clock                 system clock, all state on rising edge
//   reset                 asynchronous active-low reset
//   mode                  0 = voting, 1 = result (presses ignored while idle)
//   button1..button4      raw asynchronous candidate buttons, active-high
//   cand1..4_vote_valid   registered one-cycle pulse per accepted vote
//   vote_reject           registered one-cycle pulse per ambiguous press
//   busy                  high whenever the capture FSM is not idle
//   total_votes           saturating accepted-vote count (VOTE_CAPTURE_TOTAL_EN only)
//   reject_count          saturating reject count (VOTE_CAPTURE_TOTAL_EN only)
//
// Optional feature macro: VOTE_CAPTURE_TOTAL_EN
module vote_capture #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LOCKOUT_CYCLES  = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic       button1,
    input  logic       button2,
    input  logic       button3,
    input  logic       button4,
    output logic       cand1_vote_valid,
    output logic       cand2_vote_valid,
    output logic       cand3_vote_valid,
    output logic       cand4_vote_valid,
    output logic       vote_reject,
    output logic       busy
`ifdef VOTE_CAPTURE_TOTAL_EN
    ,
    output logic [7:0] total_votes,
    output logic [3:0] reject_count
`endif
);

    localparam logic [7:0]  DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] LOCK_LOAD = 16'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        VOTE,
        REJECT,
        LOCK,
        WAIT_REL
    } state_t;

    logic [3:0]  raw_btn;
    logic [3:0]  meta;
    logic [3:0]  sync;
    logic [3:0]  deb;
    logic [3:0]  deb_q;
    logic [7:0]  deb_cnt [4];
    logic [3:0]  press;
    logic        multi_held;

    state_t      state;
    state_t      state_next;
    logic [3:0]  sel;
    logic [3:0]  sel_next;
    logic [15:0] lock_cnt;
    logic [15:0] lock_cnt_next;

    logic [3:0]  valid_q;
    logic        reject_q;
    logic        busy_q;

    assign raw_btn = {button4, button3, button2, button1};

    // Two-flop synchroniser per button.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= 4'b0;
            sync <= 4'b0;
        end else begin
            meta <= raw_btn;
            sync <= meta;
        end
    end

    // Debounce: the counter measures how long sync has disagreed with the
    // debounced level; the level only flips after DEBOUNCE_CYCLES disagreeing
    // samples in a row.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            deb   <= 4'b0;
            deb_q <= 4'b0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= 8'd0;
            end
        end else begin
            deb_q <= deb;
            for (int i = 0; i < 4; i++) begin
                if (sync[i] == deb[i]) begin
                    deb_cnt[i] <= 8'd0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= ~deb[i];
                    deb_cnt[i] <= 8'd0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign press      = deb & ~deb_q;
    // More than one debounced level high: clearing the lowest set bit leaves
    // something behind.
    assign multi_held = |(deb & (deb - 4'd1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sel      <= 4'b0;
            lock_cnt <= 16'd0;
        end else begin
            state    <= state_next;
            sel      <= sel_next;
            lock_cnt <= lock_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        sel_next      = sel;
        lock_cnt_next = lock_cnt;
        case (state)
            IDLE: begin
                if (!mode && (press != 4'b0)) begin
                    if (multi_held) begin
                        state_next = REJECT;
                    end else begin
                        // Only one level is high, so press is already one-hot.
                        sel_next   = press;
                        state_next = VOTE;
                    end
                end
            end
            VOTE: begin
                lock_cnt_next = LOCK_LOAD;
                state_next    = LOCK;
            end
            REJECT: begin
                state_next = WAIT_REL;
            end
            LOCK: begin
                if (lock_cnt == 16'd0) begin
                    state_next = WAIT_REL;
                end else begin
                    lock_cnt_next = lock_cnt - 16'd1;
                end
            end
            WAIT_REL: begin
                if (deb == 4'b0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pulses are registered from the current state so each lasts exactly one
    // cycle; busy is registered from next state so it tracks the state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q  <= 4'b0;
            reject_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            valid_q  <= (state == VOTE) ? sel : 4'b0;
            reject_q <= (state == REJECT);
            busy_q   <= (state_next != IDLE);
        end
    end

    assign cand1_vote_valid = valid_q[0];
    assign cand2_vote_valid = valid_q[1];
    assign cand3_vote_valid = valid_q[2];
    assign cand4_vote_valid = valid_q[3];
    assign vote_reject      = reject_q;
    assign busy             = busy_q;

`ifdef VOTE_CAPTURE_TOTAL_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            total_votes  <= 8'd0;
            reject_count <= 4'd0;
        end else begin
            if ((valid_q != 4'b0) && (total_votes != 8'hFF)) begin
                total_votes <= total_votes + 8'd1;
            end
            if (reject_q && (reject_count != 4'hF)) begin
                reject_count <= reject_count + 4'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vote_capture.sv
// tb/tb_vote_capture.sv - self-checking bench for vote_capture
module tb_vote_capture;

    localparam int D  = 4;
    localparam int L  = 8;
    localparam int NR = 3000;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic mode = 1'b0;
    logic button1 = 1'b0;
    logic button2 = 1'b0;
    logic button3 = 1'b0;
    logic button4 = 1'b0;
    logic cand1_vote_valid;
    logic cand2_vote_valid;
    logic cand3_vote_valid;
    logic cand4_vote_valid;
    logic vote_reject;
    logic busy;
`ifdef VOTE_CAPTURE_TOTAL_EN
    logic [7:0] total_votes;
    logic [3:0] reject_count;
`endif

    int checks = 0;
    int failures = 0;
    int cnt_valid [4];
    int cnt_rej = 0;
    int proto_err = 0;
    int busy_seen = 0;
    logic prev_any = 1'b0;

    typedef struct {
        string      name;
        logic [3:0] btn;
        logic       md;
        int         hold;
        logic [3:0] exp_mask;
        int         exp_rej;
    } vec_t;

    vec_t vecs[$];

    logic [3:0] m_raw [NR];
    logic       m_mode [NR];
    logic [3:0] m_deb [NR];

    always #5 clock = ~clock;

    vote_capture #(
        .DEBOUNCE_CYCLES(D),
        .LOCKOUT_CYCLES (L)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .mode            (mode),
        .button1         (button1),
        .button2         (button2),
        .button3         (button3),
        .button4         (button4),
        .cand1_vote_valid(cand1_vote_valid),
        .cand2_vote_valid(cand2_vote_valid),
        .cand3_vote_valid(cand3_vote_valid),
        .cand4_vote_valid(cand4_vote_valid),
        .vote_reject     (vote_reject),
        .busy            (busy)
`ifdef VOTE_CAPTURE_TOTAL_EN
        ,
        .total_votes     (total_votes),
        .reject_count    (reject_count)
`endif
    );

    function automatic logic [3:0] valid_vec();
        return {cand4_vote_valid, cand3_vote_valid, cand2_vote_valid, cand1_vote_valid};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic set_buttons(input logic [3:0] b);
        {button4, button3, button2, button1} = b;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) cnt_valid[i] = 0;
        cnt_rej   = 0;
        busy_seen = 0;
    endtask

    // Advance one clock and sample outputs 2 time units after the edge.
    task automatic tick();
        logic [3:0] v;
        @(posedge clock);
        #2;
        v = valid_vec();
        for (int i = 0; i < 4; i++) if (v[i]) cnt_valid[i]++;
        if (vote_reject) cnt_rej++;
        if ($countones({v, vote_reject}) > 1) proto_err++;
        if (prev_any && (v != 4'b0)) proto_err++;
        prev_any = (v != 4'b0);
        if (busy) busy_seen++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mode  = 1'b0;
        set_buttons(4'b0);
        @(posedge clock);
        @(posedge clock);
        #2;
        reset    = 1'b1;
        prev_any = 1'b0;
        clear_counts();
    endtask

    task automatic apply_vector(input vec_t v);
        clear_counts();
        mode = v.md;
        set_buttons(v.btn);
        repeat (v.hold) tick();
        set_buttons(4'b0);
        repeat (D + L + 12) tick();
        mode = 1'b0;
        repeat (D + 4) tick();
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_cand%0d", v.name, i + 1), cnt_valid[i], int'(v.exp_mask[i]));
        check({v.name, "_reject"}, cnt_rej, v.exp_rej);
        check({v.name, "_busy_end"}, int'(busy), 0);
    endtask

    function automatic logic [3:0] get_raw(input int k);
        return (k >= 0) ? m_raw[k] : 4'b0;
    endfunction

    function automatic logic [3:0] get_deb(input int k);
        return (k >= 0) ? m_deb[k] : 4'b0;
    endfunction

    // Reference: a debounced level flips once the last D synchronised
    // samples (raw delayed by two clocks) all disagree with it; the capture
    // sequence is tracked as "in a sequence until release is allowed and seen".
    task automatic run_random();
        int         cd [4];
        int         mcd;
        logic [3:0] lvl;
        logic       mlvl;
        bit         in_seq;
        int         pend_edge;
        logic [3:0] pend_valid;
        logic       pend_rej;
        int         rel_from;
        int         rfail;
        logic [3:0] exp_valid;
        logic       exp_rej;
        logic [3:0] d_prev;
        logic [3:0] rise;
        logic [5:0] exp_vec;
        logic [5:0] act_vec;
        do_reset();
        for (int i = 0; i < 4; i++) cd[i] = 0;
        mcd = 0; lvl = 4'b0; mlvl = 1'b0;
        in_seq = 0; pend_edge = -1; pend_valid = 4'b0; pend_rej = 1'b0; rel_from = 0;
        rfail = 0;
        for (int n = 0; n < NR; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (cd[i] == 0) begin
                    lvl[i] = ($urandom_range(0, 3) == 0);
                    cd[i]  = $urandom_range(1, 12);
                end
                cd[i]--;
            end
            if (mcd == 0) begin
                mlvl = ($urandom_range(0, 5) == 0);
                mcd  = $urandom_range(5, 40);
            end
            mcd--;
            m_raw[n]  = lvl;
            m_mode[n] = mlvl;
            set_buttons(lvl);
            mode = mlvl;
            tick();

            d_prev = get_deb(n - 1);
            for (int i = 0; i < 4; i++) begin
                bit all_diff;
                all_diff = 1;
                for (int k = 1; k <= D; k++)
                    if (get_raw(n - k - 1)[i] == d_prev[i]) all_diff = 0;
                m_deb[n][i] = d_prev[i] ^ all_diff;
            end

            exp_valid = 4'b0;
            exp_rej   = 1'b0;
            if (n == pend_edge) begin
                exp_valid = pend_valid;
                exp_rej   = pend_rej;
            end
            if (!in_seq) begin
                rise = get_deb(n - 1) & ~get_deb(n - 2);
                if (!m_mode[n] && (rise != 4'b0)) begin
                    in_seq    = 1;
                    pend_edge = n + 1;
                    if ($countones(get_deb(n - 1)) == 1) begin
                        pend_valid = get_deb(n - 1);
                        pend_rej   = 1'b0;
                        rel_from   = n + 2 + L;
                    end else begin
                        pend_valid = 4'b0;
                        pend_rej   = 1'b1;
                        rel_from   = n + 2;
                    end
                end
            end else if ((n >= rel_from) && (get_deb(n - 1) == 4'b0)) begin
                in_seq = 0;
            end

            exp_vec = {exp_valid, exp_rej, in_seq};
            act_vec = {valid_vec(), vote_reject, busy};
            checks++;
            if (act_vec != exp_vec) begin
                failures++;
                rfail++;
                $display("FAIL random_cycle%0d outputs actual=%b expected=%b", n, act_vec, exp_vec);
                if (rfail >= 10) break;
            end
        end
        set_buttons(4'b0);
        mode = 1'b0;
        repeat (D + L + 10) tick();
    endtask

    initial begin
        int lat;
        int found;

        vecs.push_back('{"b2_hold20",      4'b0010, 1'b0, 20,    4'b0010, 0});
        vecs.push_back('{"b3b4_same",      4'b1100, 1'b0, 10,    4'b0000, 1});
        vecs.push_back('{"b3_after_rej",   4'b0100, 1'b0, 10,    4'b0100, 0});
        vecs.push_back('{"mode1_b1",       4'b0001, 1'b1, 10,    4'b0000, 0});
        vecs.push_back('{"mode0_b1",       4'b0001, 1'b0, 10,    4'b0001, 0});
        vecs.push_back('{"b1_across_lock", 4'b0001, 1'b0, 40,    4'b0001, 0});
        vecs.push_back('{"b1_repress",     4'b0001, 1'b0, 10,    4'b0001, 0});
        vecs.push_back('{"b4_hold_D",      4'b1000, 1'b0, D,     4'b1000, 0});
        vecs.push_back('{"b4_hold_Dm1",    4'b1000, 1'b0, D - 1, 4'b0000, 0});
        vecs.push_back('{"all_four",       4'b1111, 1'b0, 10,    4'b0000, 1});

        do_reset();
        check("reset_valid", int'(valid_vec()), 0);
        check("reset_reject", int'(vote_reject), 0);
        check("reset_busy", int'(busy), 0);

        // Latency of a clean press, busy while held.
        clear_counts();
        set_buttons(4'b0010);
        lat = -1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (cand2_vote_valid) begin
                lat = k;
                break;
            end
        end
        check("latency_b2", lat, D + 3);
        repeat (12) tick();
        check("busy_while_held", int'(busy), 1);
        set_buttons(4'b0);
        repeat (D + 8) tick();
        check("busy_after_release", int'(busy), 0);
        check("latency_b2_count", cnt_valid[1], 1);
        check("latency_other", cnt_valid[0] + cnt_valid[2] + cnt_valid[3] + cnt_rej, 0);

        // Short glitches never debounce.
        clear_counts();
        repeat (5) begin
            set_buttons(4'b0001);
            repeat (D - 1) tick();
            set_buttons(4'b0);
            repeat (D - 1) tick();
        end
        repeat (10) tick();
        check("glitch_valid", cnt_valid[0] + cnt_valid[1] + cnt_valid[2] + cnt_valid[3], 0);
        check("glitch_reject", cnt_rej, 0);
        check("glitch_busy", busy_seen, 0);

        foreach (vecs[i]) apply_vector(vecs[i]);

        // Reset asserted while locked out.
        clear_counts();
        set_buttons(4'b0001);
        found = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (cand1_vote_valid) begin
                found = 1;
                break;
            end
        end
        check("lock_entry_vote", found, 1);
        repeat (3) tick();
        check("lock_busy", int'(busy), 1);
        reset = 1'b0;
        set_buttons(4'b0);
        #1;
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_valid", int'(valid_vec()), 0);
        check("async_reset_reject", int'(vote_reject), 0);
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b1;
        clear_counts();
        repeat (20) tick();
        check("post_reset_quiet", cnt_valid[0] + cnt_valid[1] + cnt_valid[2] + cnt_valid[3] + cnt_rej, 0);
        set_buttons(4'b1000);
        repeat (10) tick();
        set_buttons(4'b0);
        repeat (D + L + 10) tick();
        check("post_reset_b4", cnt_valid[3], 1);
        check("post_reset_others", cnt_valid[0] + cnt_valid[1] + cnt_valid[2] + cnt_rej, 0);

`ifdef VOTE_CAPTURE_TOTAL_EN
        do_reset();
        check("total_reset", int'(total_votes), 0);
        check("rejcnt_reset", int'(reject_count), 0);
        for (int k = 0; k < 260; k++) begin
            set_buttons(4'(1 << (k % 4)));
            repeat (D + 1) tick();
            set_buttons(4'b0);
            repeat (D + L + 8) tick();
            if (k == 9) check("total_after_10", int'(total_votes), 10);
        end
        check("total_saturated", int'(total_votes), 255);
        check("total_pulses", cnt_valid[0] + cnt_valid[1] + cnt_valid[2] + cnt_valid[3], 260);
        repeat (3) begin
            set_buttons(4'b0011);
            repeat (6) tick();
            set_buttons(4'b0);
            repeat (D + 12) tick();
        end
        check("reject_count_3", int'(reject_count), 3);
`endif

        run_random();

        check("protocol_onehot_nonconsec", proto_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
